gf180mcu_fd_sc_mcu9t5v0__clkdiv_gate: RTL and testbench

GF180MCU_FD_SC_MCU9T5V0__CLKDIV_GATE -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__clkdiv_gate

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_gate.sv | 110 +++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_gate.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_gate.sv
// Glitch-free programmable clock divider (ratio DIV+2) with registered output,
// period-boundary stop/start and deferred ratio reload with acknowledge strobe.
module gf180mcu_fd_sc_mcu9t5v0__clkdiv_gate #(
    parameter int DIV_W   = 4,
    parameter int DIV_RST = 0
) (
`ifdef USE_POWER_PINS
    inout  wire              VDD,
    inout  wire              VSS,
`endif
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    input  logic [DIV_W-1:0] DIV,
    input  logic             DIV_LD,
    output logic             Z,
    output logic             Z_RISE,
    output logic             DIV_ACK,
    output logic             RUN
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]       state, nxt_state;
    logic [DIV_W:0]   count, nxt_count;
    logic [DIV_W-1:0] cur, nxt_cur;
    logic [DIV_W-1:0] pend_val, nxt_pend_val;
    logic             pend, nxt_pend;
    logic             nxt_ack;
    logic             nxt_z;
    logic             nxt_rise;
    logic [DIV_W:0]   ratio_cur;
    logic [DIV_W:0]   nxt_ratio;
    logic [DIV_W+1:0] nxt_half;
    logic             at_end;

    assign ratio_cur = {1'b0, cur} + (DIV_W+1)'(2);
    assign at_end    = (count == ratio_cur - (DIV_W+1)'(1));

    always_comb begin
        nxt_state    = state;
        nxt_count    = count;
        nxt_cur      = cur;
        nxt_pend     = pend;
        nxt_pend_val = pend_val;
        nxt_ack      = 1'b0;
        if (state == IDLE) begin
            if (pend) begin
                nxt_cur  = pend_val;
                nxt_pend = 1'b0;
                nxt_ack  = 1'b1;
            end
            if (EN) begin
                nxt_state = ACTIVE;
                nxt_count = '0;
            end
        end else if (at_end) begin
            nxt_count = '0;
            if (EN) begin
                if (pend) begin
                    nxt_cur  = pend_val;
                    nxt_pend = 1'b0;
                    nxt_ack  = 1'b1;
                end
            end else begin
                // A pending ratio survives the stop and is applied from IDLE.
                nxt_state = IDLE;
            end
        end else begin
            nxt_count = count + (DIV_W+1)'(1);
        end
        // Capture after the apply decision so a load on the boundary edge
        // only takes effect at the following boundary.
        if (DIV_LD) begin
            nxt_pend     = 1'b1;
            nxt_pend_val = DIV;
        end
    end

    assign nxt_ratio = {1'b0, nxt_cur} + (DIV_W+1)'(2);
    assign nxt_half  = ({1'b0, nxt_ratio} + (DIV_W+2)'(1)) >> 1;
    assign nxt_z     = (nxt_state == ACTIVE) && ({1'b0, nxt_count} < nxt_half);
    assign nxt_rise  = (nxt_state == ACTIVE) && (nxt_count == '0);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state    <= IDLE;
            count    <= '0;
            cur      <= DIV_W'(DIV_RST);
            pend     <= 1'b0;
            pend_val <= '0;
            Z        <= 1'b0;
            Z_RISE   <= 1'b0;
            DIV_ACK  <= 1'b0;
            RUN      <= 1'b0;
        end else begin
            state    <= nxt_state;
            count    <= nxt_count;
            cur      <= nxt_cur;
            pend     <= nxt_pend;
            pend_val <= nxt_pend_val;
            Z        <= nxt_z;
            Z_RISE   <= nxt_rise;
            DIV_ACK  <= nxt_ack;
            RUN      <= (nxt_state == ACTIVE);
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_gate.sv
// Bench for the clock divider: directed scenarios plus random traffic against
// a period-queue reference model.
module tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_gate;

    logic       clk;
    logic       rn;
    logic       en;
    logic [3:0] div;
    logic       div_ld;
    logic       z;
    logic       z_rise;
    logic       div_ack;
    logic       run;

    int total = 0;
    int bad   = 0;

    gf180mcu_fd_sc_mcu9t5v0__clkdiv_gate #(.DIV_W(4), .DIV_RST(0)) dut (
        .CLK(clk), .RN(rn), .EN(en), .DIV(div), .DIV_LD(div_ld),
        .Z(z), .Z_RISE(z_rise), .DIV_ACK(div_ack), .RUN(run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each period is a queue of Z levels built from R.
    logic [0:0] exp_q[$];
    int         m_ratio;
    logic       m_run, m_pend, m_z, m_rise, m_ack;
    logic [3:0] m_pend_val;

    function automatic logic [3:0] obs();
        return {z, z_rise, div_ack, run};
    endfunction

    function automatic logic [3:0] expv();
        return {m_z, m_rise, m_ack, m_run};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_ratio = 0 + 2;
        m_run = 0; m_pend = 0; m_pend_val = 0;
        m_z = 0; m_rise = 0; m_ack = 0;
    endtask

    task automatic model_step(input logic e, input logic [3:0] d, input logic ld);
        logic start;
        start  = 0;
        m_rise = 0;
        m_ack  = 0;
        if (m_run && exp_q.size() != 0) begin
            m_z = exp_q.pop_front();
        end else begin
            if (m_pend && (!m_run || e)) begin
                m_ratio = int'(m_pend_val) + 2;
                m_pend  = 0;
                m_ack   = 1;
            end
            start = e;
            if (start) begin
                for (int k = 0; k < m_ratio; k++) exp_q.push_back(k < (m_ratio + 1) / 2);
                m_z    = exp_q.pop_front();
                m_rise = 1;
                m_run  = 1;
            end else begin
                m_z   = 0;
                m_run = 0;
            end
        end
        if (ld) begin
            m_pend     = 1;
            m_pend_val = d;
        end
    endtask

    task automatic step(input logic e, input logic [3:0] d, input logic ld);
        en = e; div = d; div_ld = ld;
        @(posedge clk);
        model_step(e, d, ld);
        #1;
    endtask

    task automatic go_idle();
        int n;
        n = 0;
        while (m_run && n < 40) begin
            step(0, 4'd0, 0);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL go_idle: got=%b want=%b", obs(), expv());
            end
            n++;
        end
        total++;
        if (m_run) begin
            bad++;
            $display("FAIL go_idle_timeout: model still running after %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        rn = 0; en = 0; div = 0; div_ld = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs() !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs: got=%b want=0000", obs());
        end
        rn = 1;
        step(1, 4'd0, 0);
        total++;
        if (obs() !== 4'b1101) begin
            bad++;
            $display("FAIL first_cycle_after_start: got=%b want=1101", obs());
        end
    endtask

    task automatic test_div2_free_run();
        for (int i = 0; i < 10; i++) begin
            step(1, 4'd0, 0);
            total++;
            if (obs() !== expv() || z !== (i % 2 == 1)) begin
                bad++;
                $display("FAIL div2_run[%0d]: got=%b want=%b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_load_idle();
        go_idle();
        step(0, 4'd1, 1);
        for (int i = 0; i < 11; i++) begin
            step(i > 0, 4'd0, 0);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL load_idle[%0d]: got=%b want=%b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_en_drop();
        go_idle();
        step(0, 4'd4, 1);
        step(0, 4'd0, 0);
        for (int i = 0; i < 12; i++) begin
            step(i < 2, 4'd0, 0);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL en_drop[%0d]: got=%b want=%b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_double_load();
        logic [3:0] dv [0:15];
        logic       ld [0:15];
        for (int i = 0; i < 16; i++) begin dv[i] = 0; ld[i] = 0; end
        dv[3] = 4'd3; ld[3] = 1;
        dv[4] = 4'd0; ld[4] = 1;
        go_idle();
        step(0, 4'd2, 1);
        step(0, 4'd0, 0);
        for (int i = 0; i < 16; i++) begin
            step(i > 0, dv[i], ld[i]);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL double_load[%0d]: got=%b want=%b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_boundary_load();
        go_idle();
        step(0, 4'd1, 1);
        step(0, 4'd0, 0);
        for (int i = 0; i < 18; i++) begin
            step(i > 0, 4'd4, i == 3);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL boundary_load[%0d]: got=%b want=%b", i, obs(), expv());
            end
        end
    endtask

    task automatic async_reset_pulse(input string tag);
        #3 rn = 0;
        #1;
        model_reset();
        total++;
        if (obs() !== 4'b0000) begin
            bad++;
            $display("FAIL %s_async: got=%b want=0000", tag, obs());
        end
        @(posedge clk);
        #1;
        rn = 1;
    endtask

    task automatic test_async_reset();
        go_idle();
        step(0, 4'd3, 1);
        step(0, 4'd0, 0);
        step(1, 4'd0, 0);
        step(1, 4'd0, 0);
        step(1, 4'd0, 0);
        async_reset_pulse("mid_period");
        for (int i = 0; i < 8; i++) begin
            step(1, 4'd0, 0);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL after_reset[%0d]: got=%b want=%b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                async_reset_pulse("random");
            end else begin
                step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 6) == 0);
                total++;
                if (obs() !== expv()) begin
                    bad++;
                    $display("FAIL random[%0d]: got=%b want=%b", i, obs(), expv());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_div2_free_run();
        test_load_idle();
        test_en_drop();
        test_double_load();
        test_boundary_load();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
